// File: rtl/common_pkg.sv
// Types and constants shared by the fetch stage and the instruction-bus side.
// Holds the fetch FSM states, the fault filler word and the ibus request/response records.
package common;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fb_state_t;

    // Word presented in place of bus data when the held entry is a fault.
    localparam logic [31:0] FB_NOP = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    function automatic logic pc_misaligned(input logic [63:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: one outstanding ibus request, holds the returned word until retire.
// Flushes during a request are absorbed by draining the bus; misaligned PCs fault without a request.
module fetch_buffer
    import common::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_en,
    input  logic [63:0]      pc,
    input  logic             retire,
    input  logic             flush,
    output ibus_req_t        ireq,
    input  ibus_resp_t       iresp,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [63:0]      instr_pc,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_cnt
);

    fb_state_t   state;
    logic [63:0] addr_q;
    logic [31:0] instr_q;
    logic        mis_q;
    logic        req_valid_q;
    logic        instr_valid_q;
    logic        misalign_q;

    // Output flags are kept as registers alongside the state so nothing downstream sees decode logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= 64'h0;
            instr_q       <= 32'h0;
            mis_q         <= 1'b0;
            fetch_cnt     <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en && !flush) begin
                        addr_q <= pc;
                        if (pc_misaligned(pc)) begin
                            state         <= HOLD;
                            mis_q         <= 1'b1;
                            instr_q       <= FB_NOP;
                            fetch_cnt     <= fetch_cnt + CNT_W'(1);
                            instr_valid_q <= 1'b1;
                            misalign_q    <= 1'b1;
                        end else begin
                            state       <= REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (iresp.data_ok) begin
                        req_valid_q <= 1'b0;
                        if (!flush) begin
                            state         <= HOLD;
                            instr_q       <= iresp.data;
                            mis_q         <= 1'b0;
                            fetch_cnt     <= fetch_cnt + CNT_W'(1);
                            instr_valid_q <= 1'b1;
                            misalign_q    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    // The request cannot be withdrawn, so wait out the response and discard it.
                    if (iresp.data_ok) begin
                        state       <= IDLE;
                        req_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush || retire) begin
                        state         <= IDLE;
                        instr_valid_q <= 1'b0;
                        misalign_q    <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    req_valid_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                    misalign_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ireq       = '0;
        ireq.valid = req_valid_q;
        ireq.addr  = addr_q;
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = addr_q;
    assign misalign    = misaligned_out(misalign_q, mis_q);

    function automatic logic misaligned_out(input logic flag, input logic held);
        return flag & held;
    endfunction

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: scenario tasks with a scoreboard of expected deliveries.
module tb_fetch_buffer;
    import common::*;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [63:0] pc;
    logic        retire;
    logic        flush;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        misalign;
    logic [31:0] fetch_cnt;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_cnt;
    exp_t        sb_q[$];

    fetch_buffer #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .pc         (pc),
        .retire     (retire),
        .flush      (flush),
        .ireq       (ireq),
        .iresp      (iresp),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .misalign   (misalign),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pop_expected(output exp_t e);
        if (sb_q.size() == 0) begin
            e.instr = 'x;
            e.pc    = 'x;
            e.mis   = 1'bx;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_en = 1'b0; pc = 64'h0; retire = 1'b0; flush = 1'b0;
        iresp = '0;
        tick(); tick();
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ireq_valid got %b want 0", ireq.valid); end
        tests_run++; if (ireq.addr !== 64'h0) begin tests_failed++; $display("FAIL reset_ireq_addr got %h want 0", ireq.addr); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        tests_run++; if (instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h want 0", instr); end
        tests_run++; if (instr_pc !== 64'h0) begin tests_failed++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
        tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got %b want 0", misalign); end
        tests_run++; if (fetch_cnt !== 32'h0) begin tests_failed++; $display("FAIL reset_fetch_cnt got %0d want 0", fetch_cnt); end
        reset = 1'b0;
        exp_cnt = 32'h0;
        tick();
    endtask

    task automatic test_aligned();
        exp_t e;
        pc = 64'h8000_0000; fetch_en = 1'b1;
        sb_q.push_back('{instr: 32'h0000_0093, pc: 64'h8000_0000, mis: 1'b0});
        tick();
        fetch_en = 1'b0;
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin tests_failed++; $display("FAIL aligned_req got valid=%b addr=%h want 1/80000000", ireq.valid, ireq.addr); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL aligned_early_valid got %b want 0", instr_valid); end
        iresp.data_ok = 1'b1; iresp.data = 32'h0000_0093;
        tick();
        iresp.data_ok = 1'b0;
        exp_cnt++;
        pop_expected(e);
        tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL aligned_valid got %b want 1", instr_valid); end
        tests_run++; if (instr !== e.instr || instr_pc !== e.pc || misalign !== e.mis) begin tests_failed++; $display("FAIL aligned_data got %h@%h mis=%b want %h@%h mis=%b", instr, instr_pc, misalign, e.instr, e.pc, e.mis); end
        tests_run++; if (fetch_cnt !== exp_cnt) begin tests_failed++; $display("FAIL aligned_cnt got %0d want %0d", fetch_cnt, exp_cnt); end
        $display("[TB] aligned fetch instr=%h pc=%h cnt=%0d", instr, instr_pc, fetch_cnt);
        tick(); tick();
        tests_run++; if (instr_valid !== 1'b1 || instr !== e.instr || ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL aligned_hold got valid=%b instr=%h req=%b want 1/%h/0", instr_valid, instr, ireq.valid, e.instr); end
        retire = 1'b1;
        tick();
        retire = 1'b0;
        tests_run++; if (instr_valid !== 1'b0 || ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL aligned_retire got valid=%b req=%b want 0/0", instr_valid, ireq.valid); end
    endtask

    task automatic test_wait_states();
        exp_t e;
        pc = 64'h8000_0004; fetch_en = 1'b1;
        sb_q.push_back('{instr: 32'h00A0_0513, pc: 64'h8000_0004, mis: 1'b0});
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0004 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL wait_req_stable cyc%0d got valid=%b addr=%h iv=%b want 1/80000004/0", i, ireq.valid, ireq.addr, instr_valid); end
            if (i == 3) begin iresp.data_ok = 1'b1; iresp.data = 32'h00A0_0513; end
            tick();
        end
        iresp.data_ok = 1'b0;
        exp_cnt++;
        pop_expected(e);
        tests_run++; if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc) begin tests_failed++; $display("FAIL wait_deliver got valid=%b %h@%h want 1 %h@%h", instr_valid, instr, instr_pc, e.instr, e.pc); end
        tests_run++; if (fetch_cnt !== exp_cnt) begin tests_failed++; $display("FAIL wait_cnt got %0d want %0d", fetch_cnt, exp_cnt); end
        $display("[TB] wait-state fetch instr=%h pc=%h cnt=%0d", instr, instr_pc, fetch_cnt);
        retire = 1'b1; tick(); retire = 1'b0;
    endtask

    task automatic test_flush_in_flight();
        exp_t e;
        pc = 64'h8000_0008; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        flush = 1'b1;
        tests_run++; if (ireq.valid !== 1'b1) begin tests_failed++; $display("FAIL flush_req got %b want 1", ireq.valid); end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0008 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_drop cyc%0d got valid=%b addr=%h iv=%b want 1/80000008/0", i, ireq.valid, ireq.addr, instr_valid); end
            if (i == 1) begin iresp.data_ok = 1'b1; iresp.data = 32'hDEAD_BEEF; end
            tick();
        end
        iresp.data_ok = 1'b0;
        tests_run++; if (ireq.valid !== 1'b0 || instr_valid !== 1'b0 || fetch_cnt !== exp_cnt) begin tests_failed++; $display("FAIL flush_discard got req=%b iv=%b cnt=%0d want 0/0/%0d", ireq.valid, instr_valid, fetch_cnt, exp_cnt); end
        $display("[TB] flushed fetch pc=80000008 discarded, cnt=%0d", fetch_cnt);
        pc = 64'h8000_000C; fetch_en = 1'b1;
        sb_q.push_back('{instr: 32'h0010_0073, pc: 64'h8000_000C, mis: 1'b0});
        tick();
        fetch_en = 1'b0;
        iresp.data_ok = 1'b1; iresp.data = 32'h0010_0073;
        tick();
        iresp.data_ok = 1'b0;
        exp_cnt++;
        pop_expected(e);
        tests_run++; if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc || fetch_cnt !== exp_cnt) begin tests_failed++; $display("FAIL flush_next got iv=%b %h@%h cnt=%0d want 1 %h@%h cnt=%0d", instr_valid, instr, instr_pc, fetch_cnt, e.instr, e.pc, exp_cnt); end
        $display("[TB] post-flush fetch instr=%h pc=%h cnt=%0d", instr, instr_pc, fetch_cnt);
        retire = 1'b1; tick(); retire = 1'b0;
    endtask

    task automatic test_flush_same_cycle();
        pc = 64'h8000_0010; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        flush = 1'b1; iresp.data_ok = 1'b1; iresp.data = 32'h1234_5678;
        tick();
        flush = 1'b0; iresp.data_ok = 1'b0;
        tests_run++; if (ireq.valid !== 1'b0 || instr_valid !== 1'b0 || fetch_cnt !== exp_cnt) begin tests_failed++; $display("FAIL flush_same got req=%b iv=%b cnt=%0d want 0/0/%0d", ireq.valid, instr_valid, fetch_cnt, exp_cnt); end
        tick();
        tests_run++; if (ireq.valid !== 1'b0 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_same_idle got req=%b iv=%b want 0/0", ireq.valid, instr_valid); end
        $display("[TB] same-cycle flush pc=80000010 discarded, cnt=%0d", fetch_cnt);
    endtask

    task automatic test_misaligned();
        exp_t e;
        pc = 64'h8000_0002; fetch_en = 1'b1;
        sb_q.push_back('{instr: 32'h0, pc: 64'h8000_0002, mis: 1'b1});
        tick();
        fetch_en = 1'b0;
        exp_cnt++;
        pop_expected(e);
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL mis_noreq got %b want 0", ireq.valid); end
        tests_run++; if (instr_valid !== 1'b1 || misalign !== e.mis || instr !== e.instr || instr_pc !== e.pc) begin tests_failed++; $display("FAIL mis_hold got iv=%b mis=%b %h@%h want 1/%b %h@%h", instr_valid, misalign, instr, instr_pc, e.mis, e.instr, e.pc); end
        tests_run++; if (fetch_cnt !== exp_cnt) begin tests_failed++; $display("FAIL mis_cnt got %0d want %0d", fetch_cnt, exp_cnt); end
        $display("[TB] misaligned fault pc=%h cnt=%0d", instr_pc, fetch_cnt);
        retire = 1'b1; tick(); retire = 1'b0;
        tests_run++; if (instr_valid !== 1'b0 || misalign !== 1'b0 || ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL mis_retire got iv=%b mis=%b req=%b want 0/0/0", instr_valid, misalign, ireq.valid); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] d;
        int          w;
        fetch_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pc = 64'h8000_1000 + 64'(k * 4);
            d  = $urandom;
            w  = $urandom_range(0, 2);
            sb_q.push_back('{instr: d, pc: pc, mis: 1'b0});
            tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle k%0d got req=%b want 0", k, ireq.valid); end
            tick();
            for (int i = 0; i <= w; i++) begin
                tests_run++; if (ireq.valid !== 1'b1 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_req k%0d got req=%b iv=%b want 1/0", k, ireq.valid, instr_valid); end
                if (i == w) begin iresp.data_ok = 1'b1; iresp.data = d; end
                tick();
            end
            iresp.data_ok = 1'b0;
            exp_cnt++;
            pop_expected(e);
            tests_run++; if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc || fetch_cnt !== exp_cnt) begin tests_failed++; $display("FAIL b2b_deliver k%0d got iv=%b %h@%h cnt=%0d want 1 %h@%h cnt=%0d", k, instr_valid, instr, instr_pc, fetch_cnt, e.instr, e.pc, exp_cnt); end
            $display("[TB] b2b fetch %0d instr=%h pc=%h waits=%0d cnt=%0d", k, instr, instr_pc, w, fetch_cnt);
            retire = 1'b1;
            tick();
            retire = 1'b0;
        end
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_req_and_wrap();
        exp_t e;
        pc = 64'h8000_0020; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tests_run++; if (ireq.valid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_req got %b want 1", ireq.valid); end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (ireq.valid !== 1'b0 || ireq.addr !== 64'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 64'h0 || misalign !== 1'b0 || fetch_cnt !== 32'h0) begin
            tests_failed++; $display("FAIL rst_async got req=%b addr=%h iv=%b instr=%h pc=%h mis=%b cnt=%0d want all 0", ireq.valid, ireq.addr, instr_valid, instr, instr_pc, misalign, fetch_cnt);
        end
        $display("[TB] async reset during request, outputs cleared");
        tick();
        reset = 1'b0;
        tick();
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL rst_no_drop got req=%b want 0", ireq.valid); end
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1 release dut.fetch_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        tick();
        tests_run++; if (fetch_cnt !== exp_cnt) begin tests_failed++; $display("FAIL wrap_preload got %h want %h", fetch_cnt, exp_cnt); end
        pc = 64'h8000_0040; fetch_en = 1'b1;
        sb_q.push_back('{instr: 32'h0000_0013, pc: 64'h8000_0040, mis: 1'b0});
        tick();
        fetch_en = 1'b0;
        iresp.data_ok = 1'b1; iresp.data = 32'h0000_0013;
        tick();
        iresp.data_ok = 1'b0;
        exp_cnt++;
        pop_expected(e);
        tests_run++; if (fetch_cnt !== exp_cnt || exp_cnt !== 32'h0) begin tests_failed++; $display("FAIL wrap_cnt got %h want 00000000", fetch_cnt); end
        tests_run++; if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc) begin tests_failed++; $display("FAIL wrap_deliver got iv=%b %h@%h want 1 %h@%h", instr_valid, instr, instr_pc, e.instr, e.pc); end
        $display("[TB] wrap fetch instr=%h pc=%h cnt=%0d", instr, instr_pc, fetch_cnt);
        retire = 1'b1; tick(); retire = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_wait_states();
        test_flush_in_flight();
        test_flush_same_cycle();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_req_and_wrap();
        tests_run++; if (sb_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
